// File: rtl/div_unit_if.sv
// Operand/result bundle between the control unit and the multi-cycle divider.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             DivIn;
  logic             Signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             DivStop;
  logic             DivZero;
  logic [WIDTH-1:0] resultHigh;
  logic [WIDTH-1:0] resultLow;

  modport master (
    output DivIn, Signed, A, B,
    input  Busy, DivStop, DivZero, resultHigh, resultLow
  );

  modport slave (
    input  DivIn, Signed, A, B,
    output Busy, DivStop, DivZero, resultHigh, resultLow
  );
endinterface

// File: rtl/div_unit.sv
// Restoring shift-subtract divider: one quotient bit per cycle, quotient to LO, remainder to HI.
// Signed operands are divided as magnitudes and the signs are fixed up in a final cycle.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       Reset,
  div_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             busy_q, busy_d;
  logic             stop_q, stop_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH:0]   r_shift;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    busy_d  = busy_q;
    stop_d  = 1'b0;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    r_shift = {r_q, q_q[WIDTH-1]};

    case (state_q)
      StIdle: begin
        if (bus.DivIn) begin
          if (bus.B == '0) begin
            zero_d = 1'b1;
            stop_d = 1'b1;
          end else begin
            q_d     = (bus.Signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
            d_d     = (bus.Signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
            qneg_d  = bus.Signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            rneg_d  = bus.Signed & bus.A[WIDTH-1];
            r_d     = '0;
            cnt_d   = CntW'(WIDTH);
            zero_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        // The true difference is always below 2^WIDTH, so a WIDTH-bit subtract is exact.
        if (r_shift >= {1'b0, d_q}) begin
          r_d = r_shift[WIDTH-1:0] - d_q;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = r_shift[WIDTH-1:0];
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFix;
      end
      StFix: begin
        lo_d    = qneg_q ? -q_q : q_q;
        hi_d    = rneg_q ? -r_q : r_q;
        stop_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      stop_q  <= stop_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.Busy       = busy_q;
  assign bus.DivStop    = stop_q;
  assign bus.DivZero    = zero_q;
  assign bus.resultHigh = hi_q;
  assign bus.resultLow  = lo_q;

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised multi-cycle integer divider for the MIPS datapath, computing A/B. It supports signed and unsigned modes, has a start/done handshake, and flags divide-by-zero. It uses a restoring shift-subtract algorithm that produces one quotient bit per cycle. Results go to the HI/LO path: resultLow holds the quotient and resultHigh holds the remainder. The control unit starts it with DivIn, stalls on Busy and latches results on DivStop.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits (WIDTH >= 4)

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- DivIn  input  1  start request, sampled only in IDLE
- Signed  input  1  1 = two's-complement operands (DIV), 0 = unsigned (DIVU); sampled with DivIn
- A  input  WIDTH  dividend, sampled with DivIn
- B  input  WIDTH  divisor, sampled with DivIn
- Busy  output  1  high while a division is in progress
- DivStop  output  1  one-cycle pulse: operation finished (results valid or DivZero set)
- DivZero  output  1  divide-by-zero exception flag
- resultHigh  output  WIDTH  remainder (HI)
- resultLow  output  WIDTH  quotient (LO)

## Operation
- States: IDLE, CALC, FIX.
- IDLE, DivIn=1, B!=0:
  - Latch |A| into the quotient shift register and |B| into the divisor register.
  - In unsigned mode, magnitudes are the raw values.
  - Latch the sign flags: qneg = Signed & (A[MSB]^B[MSB]); rneg = Signed & A[MSB].
  - Clear the partial remainder (WIDTH+1 bits), load count = WIDTH, clear DivZero, go to CALC.
- IDLE, DivIn=1, B==0:
  - Set DivZero=1 and DivStop=1 for one cycle, stay in IDLE.
  - resultHigh/resultLow are left unchanged.
- CALC, one iteration per cycle:
  - r = {r[WIDTH-1:0], q[MSB]}; q <<= 1.
  - If r >= d: r = r - d and q[0] = 1; else q[0] = 0.
  - Decrement count. When count reaches 0, go to FIX.
- FIX:
  - resultLow = qneg ? -q : q.
  - resultHigh = rneg ? -r : r.
  - Remainder sign follows the dividend (MIPS semantics).
  - Assert DivStop for one cycle, go to IDLE.
- Arithmetic is modulo 2^WIDTH. Signed MIN / -1 gives quotient = MIN, remainder = 0, and no exception.
- DivZero holds until the next accepted DivIn with B != 0, or until reset.
- DivIn while Busy=1 is ignored. There is no queueing and in-flight operands are not disturbed.
- A, B and Signed may change freely after the accepting edge.

## Timing
- Reset (asynchronous, Reset=0):
  - State goes to IDLE; Busy, DivStop and DivZero go to 0; resultHigh and resultLow go to 0; internal registers are cleared.
  - A reset mid-operation aborts the operation with no DivStop pulse.
- Accept edge E0 (DivIn=1 in IDLE, B!=0): Busy=1 from E0.
- CALC occupies edges E1..E_WIDTH.
- At edge E_(WIDTH+1):
  - Results are written, DivStop=1 and Busy=0.
  - Latency is WIDTH+1 cycles from the accept edge to DivStop (33 for WIDTH=32).
- DivStop is cleared at the following edge.
  - A new DivIn may be accepted at that same edge (back-to-back issue).
  - Results stay stable until the next FIX.
- Divide-by-zero: DivZero=1 and DivStop=1 from E0, DivStop drops at E1, Busy never rises.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned, WIDTH=32: A=100, B=7, Signed=0 -> DivStop exactly 33 cycles after accept; resultLow=14, resultHigh=2; Busy high for 33 cycles.
- Signed: A=-7 (0xFFFFFFF9), B=2 -> resultLow=0xFFFFFFFD (-3), resultHigh=0xFFFFFFFF (-1). Then A=7, B=-2 -> resultLow=-3, resultHigh=1.
- Divide-by-zero: A=5, B=0 -> DivZero=1 and DivStop pulse one cycle after accept, Busy stays 0, results keep their previous values. A following valid division clears DivZero.
- Corner cases:
  - Signed A=0x80000000, B=0xFFFFFFFF -> resultLow=0x80000000, resultHigh=0.
  - Unsigned A=0xFFFFFFFF, B=1 -> resultLow=0xFFFFFFFF, resultHigh=0.
  - Unsigned A=3, B=9 -> resultLow=0, resultHigh=3.
- Handshake:
  - DivIn pulsed with new operands mid-CALC -> ignored, first result is unaffected.
  - DivIn asserted on the DivStop cycle -> second division accepted, its DivStop follows 33 cycles later.
- Reset and width: Reset=0 at cycle 10 of CALC -> all outputs 0 immediately, no DivStop. Instance with WIDTH=8, A=200, B=3, unsigned -> resultLow=66, resultHigh=2, latency 9 cycles.
